// File: rtl/object_report_sequencer_pkg.sv
// Shared widths and FSM state encoding for the object report sequencer.
// Label ids are LBL_WIDTH bits; area and coordinate sums are LOC_SIZE bits.
package object_report_sequencer_pkg;

  localparam int LOC_SIZE  = 16;
  localparam int LBL_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DIV     = 3'd3,
    ST_OUT     = 3'd4,
    ST_NEXT    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/object_report_sequencer_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH cycles per divide.
// done is high during the final iteration cycle, so the quotient is final on the following cycle.
module seq_divider
  import object_report_sequencer_pkg::*;
#(
  parameter int WIDTH = LOC_SIZE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   trial;

  // Dividend bits shift out of quo's MSB while quotient bits shift in at the LSB.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
    end
  end

  assign quotient = quo;
  assign done     = (cnt == CNT_W'(1));

endmodule

// File: rtl/object_report_sequencer.sv
// Walks labels 1..num_labels after each frame, filters small objects and
// emits one centroid record per surviving label over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for frame_done
// ADDR    | obj_id presented, waiting STAT_LATENCY cycles for stats
// CAPTURE | latch stats, start dividers or skip the label
// DIV     | centroid division in progress
// OUT     | record offered, waiting for rpt_ready
// NEXT    | advance to next label or finish the sweep
module object_report_sequencer
  import object_report_sequencer_pkg::*;
#(
  parameter int STAT_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_done,
  input  logic [LBL_WIDTH-1:0] num_labels,
  input  logic [LOC_SIZE-1:0]  obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  input  logic [LOC_SIZE-1:0]  min_area,
  output logic [LBL_WIDTH-1:0] obj_id,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [LBL_WIDTH-1:0] rpt_id,
  output logic [LOC_SIZE-1:0]  rpt_area,
  output logic [LOC_SIZE-1:0]  rpt_cx,
  output logic [LOC_SIZE-1:0]  rpt_cy,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 overrun
);

  localparam int LAT_W = (STAT_LATENCY > 1) ? $clog2(STAT_LATENCY) : 1;

  seq_state_t           state;
  logic [LBL_WIDTH-1:0] snap_labels;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 div_start;
  logic                 done_x;
  logic                 done_y;

  // min_area is sampled here, in CAPTURE, so mid-sweep changes apply to later labels only.
  assign div_start = (state == ST_CAPTURE) && (obj_area != '0) && !(obj_area < min_area);

  seq_divider #(.WIDTH(LOC_SIZE)) u_div_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (obj_x),
    .divisor  (obj_area),
    .quotient (rpt_cx),
    .done     (done_x)
  );

  seq_divider #(.WIDTH(LOC_SIZE)) u_div_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (obj_y),
    .divisor  (obj_area),
    .quotient (rpt_cy),
    .done     (done_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      obj_id      <= '0;
      snap_labels <= '0;
      lat_cnt     <= '0;
      rpt_valid   <= 1'b0;
      rpt_id      <= '0;
      rpt_area    <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      // Any frame_done outside IDLE, including the final NEXT cycle, is rejected.
      overrun    <= frame_done && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (frame_done) begin
            snap_labels <= num_labels;
            if (num_labels == '0) begin
              sweep_done <= 1'b1;
            end else begin
              obj_id  <= LBL_WIDTH'(1);
              lat_cnt <= LAT_W'(STAT_LATENCY - 1);
              state   <= ST_ADDR;
              busy    <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (lat_cnt == '0) state <= ST_CAPTURE;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        ST_CAPTURE: begin
          rpt_id   <= obj_id;
          rpt_area <= obj_area;
          state    <= div_start ? ST_DIV : ST_NEXT;
        end
        ST_DIV: begin
          if (done_x && done_y) begin
            rpt_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            state     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (obj_id == snap_labels) begin
            sweep_done <= 1'b1;
            obj_id     <= '0;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end else begin
            obj_id  <= obj_id + 1'b1;
            lat_cnt <= LAT_W'(STAT_LATENCY - 1);
            state   <= ST_ADDR;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_object_report_sequencer.sv
// Directed bench for object_report_sequencer: single-label vector table plus
// hand-written multi-label, stall, overrun and reset sequences.
module tb_object_report_sequencer;
  import object_report_sequencer_pkg::*;

  localparam int LAT       = 1;
  localparam int RISE_K    = LAT + 2 + LOC_SIZE;
  localparam int MAX_CYC   = 3000;

  logic                 clk;
  logic                 reset_n;
  logic                 frame_done;
  logic [LBL_WIDTH-1:0] num_labels;
  logic [LOC_SIZE-1:0]  obj_area, obj_x, obj_y, min_area;
  logic [LBL_WIDTH-1:0] obj_id;
  logic                 rpt_valid, rpt_ready;
  logic [LBL_WIDTH-1:0] rpt_id;
  logic [LOC_SIZE-1:0]  rpt_area, rpt_cx, rpt_cy;
  logic                 busy, sweep_done, overrun;

  logic [LOC_SIZE-1:0] area_mem [0:255];
  logic [LOC_SIZE-1:0] sx_mem   [0:255];
  logic [LOC_SIZE-1:0] sy_mem   [0:255];

  assign obj_area = area_mem[obj_id];
  assign obj_x    = sx_mem[obj_id];
  assign obj_y    = sy_mem[obj_id];

  object_report_sequencer #(.STAT_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_done (frame_done),
    .num_labels (num_labels),
    .obj_area   (obj_area),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .min_area   (min_area),
    .obj_id     (obj_id),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_id     (rpt_id),
    .rpt_area   (rpt_area),
    .rpt_cx     (rpt_cx),
    .rpt_cy     (rpt_cy),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Results of the most recent run_frame
  int got_id[$], got_area[$], got_cx[$], got_cy[$];
  int first_valid_k, sweep_k, overrun_cnt, valid_cycles, unstable;
  bit busy_seen;

  task automatic run_frame(input int stall, input int inject_k, input bit scramble);
    int stall_left;
    bit hold;
    logic [LBL_WIDTH-1:0] h_id;
    logic [LOC_SIZE-1:0]  h_area, h_cx, h_cy;
    got_id.delete(); got_area.delete(); got_cx.delete(); got_cy.delete();
    first_valid_k = -1; sweep_k = -1; overrun_cnt = 0; valid_cycles = 0;
    unstable = 0; busy_seen = 0; stall_left = stall; hold = 0;
    h_id = '0; h_area = '0; h_cx = '0; h_cy = '0;
    @(negedge clk);
    frame_done = 1'b1;
    rpt_ready  = 1'b1;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(negedge clk);
      frame_done = (k == inject_k);
      if (scramble && k == 5) num_labels = '0;
      if (busy) busy_seen = 1;
      if (overrun) overrun_cnt++;
      if (rpt_valid) begin
        valid_cycles++;
        if (first_valid_k < 0) first_valid_k = k;
        if (!hold) begin
          hold = 1; h_id = rpt_id; h_area = rpt_area; h_cx = rpt_cx; h_cy = rpt_cy;
        end else if (rpt_id !== h_id || rpt_area !== h_area || rpt_cx !== h_cx || rpt_cy !== h_cy) begin
          unstable++;
        end
        if (stall_left > 0) begin
          rpt_ready = 1'b0;
          stall_left--;
        end else begin
          rpt_ready = 1'b1;
          got_id.push_back(int'(rpt_id));
          got_area.push_back(int'(rpt_area));
          got_cx.push_back(int'(rpt_cx));
          got_cy.push_back(int'(rpt_cy));
          hold = 0;
        end
      end else begin
        rpt_ready = 1'b1;
      end
      if (sweep_done) begin
        sweep_k = k;
        break;
      end
    end
    frame_done = 1'b0;
    rpt_ready  = 1'b1;
  endtask

  typedef struct {
    logic [LOC_SIZE-1:0] area, sx, sy, min_a;
    int                  exp_cnt;
    logic [LOC_SIZE-1:0] cx, cy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{area: 16'd4,     sx: 16'd10,    sy: 16'd6,     min_a: 16'd1,   exp_cnt: 1, cx: 16'd2,     cy: 16'd1};
    vecs[1] = '{area: 16'd7,     sx: 16'd100,   sy: 16'd49,    min_a: 16'd7,   exp_cnt: 1, cx: 16'd14,    cy: 16'd7};
    vecs[2] = '{area: 16'd6,     sx: 16'd1,     sy: 16'd0,     min_a: 16'd7,   exp_cnt: 0, cx: 16'd0,     cy: 16'd0};
    vecs[3] = '{area: 16'd0,     sx: 16'd5,     sy: 16'd5,     min_a: 16'd0,   exp_cnt: 0, cx: 16'd0,     cy: 16'd0};
    vecs[4] = '{area: 16'd1,     sx: 16'd65535, sy: 16'd12345, min_a: 16'd0,   exp_cnt: 1, cx: 16'd65535, cy: 16'd12345};
    vecs[5] = '{area: 16'd65535, sx: 16'd65535, sy: 16'd65534, min_a: 16'd1,   exp_cnt: 1, cx: 16'd1,     cy: 16'd0};
    vecs[6] = '{area: 16'd3,     sx: 16'd11,    sy: 16'd8,     min_a: 16'd3,   exp_cnt: 1, cx: 16'd3,     cy: 16'd2};
    vecs[7] = '{area: 16'd1000,  sx: 16'd999,   sy: 16'd50000, min_a: 16'd999, exp_cnt: 1, cx: 16'd0,     cy: 16'd50};

    for (int i = 0; i < 256; i++) begin
      area_mem[i] = '0; sx_mem[i] = '0; sy_mem[i] = '0;
    end
    area_mem[0] = 16'd9; sx_mem[0] = 16'd9; sy_mem[0] = 16'd9;
    reset_n = 1'b0; frame_done = 1'b0; num_labels = '0; min_area = '0; rpt_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_obj_id", obj_id, 0);
    chk("rst_valid", rpt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sweep", sweep_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_area", rpt_area, 0);

    // Empty frame
    num_labels = '0;
    run_frame(0, -1, 0);
    chk("empty_sweep_k", sweep_k, 1);
    chk("empty_valid", valid_cycles, 0);
    chk("empty_busy", busy_seen, 0);

    // Single-label vector table
    for (int i = 0; i < 8; i++) begin
      area_mem[1] = vecs[i].area; sx_mem[1] = vecs[i].sx; sy_mem[1] = vecs[i].sy;
      min_area = vecs[i].min_a; num_labels = 8'd1;
      run_frame(0, -1, 0);
      chk($sformatf("v%0d_sweep", i), (sweep_k > 0), 1);
      chk($sformatf("v%0d_cnt", i), got_id.size(), vecs[i].exp_cnt);
      if (vecs[i].exp_cnt == 1 && got_id.size() == 1) begin
        chk($sformatf("v%0d_id", i), got_id[0], 1);
        chk($sformatf("v%0d_area", i), got_area[0], vecs[i].area);
        chk($sformatf("v%0d_cx", i), got_cx[0], vecs[i].cx);
        chk($sformatf("v%0d_cy", i), got_cy[0], vecs[i].cy);
        chk($sformatf("v%0d_rise", i), first_valid_k, RISE_K);
        chk($sformatf("v%0d_vcyc", i), valid_cycles, 1);
      end
      chk($sformatf("v%0d_ovr", i), overrun_cnt, 0);
    end

    // Labels 1..3, areas 5,0,2, min_area 3: only label 1 survives
    area_mem[1] = 16'd5; sx_mem[1] = 16'd17; sy_mem[1] = 16'd9;
    area_mem[2] = 16'd0; sx_mem[2] = 16'd0;  sy_mem[2] = 16'd0;
    area_mem[3] = 16'd2; sx_mem[3] = 16'd4;  sy_mem[3] = 16'd2;
    min_area = 16'd3; num_labels = 8'd3;
    run_frame(0, -1, 0);
    chk("filt_sweep", (sweep_k > 0), 1);
    chk("filt_cnt", got_id.size(), 1);
    if (got_id.size() > 0) begin
      chk("filt_id", got_id[0], 1);
      chk("filt_cx", got_cx[0], 3);
      chk("filt_cy", got_cy[0], 1);
    end

    // Three valid labels, ascending order; num_labels cleared mid-sweep
    area_mem[1] = 16'd2; sx_mem[1] = 16'd5;  sy_mem[1] = 16'd1;
    area_mem[2] = 16'd3; sx_mem[2] = 16'd9;  sy_mem[2] = 16'd2;
    area_mem[3] = 16'd4; sx_mem[3] = 16'd13; sy_mem[3] = 16'd3;
    min_area = 16'd0; num_labels = 8'd3;
    run_frame(0, -1, 1);
    chk("ord_cnt", got_id.size(), 3);
    if (got_id.size() == 3) begin
      chk("ord_id0", got_id[0], 1);
      chk("ord_id1", got_id[1], 2);
      chk("ord_id2", got_id[2], 3);
      chk("ord_cx0", got_cx[0], 2);
      chk("ord_cx1", got_cx[1], 3);
      chk("ord_cx2", got_cx[2], 3);
      chk("ord_area2", got_area[2], 4);
    end
    chk("ord_vcyc", valid_cycles, 3);

    // Consumer stalls 10 cycles
    area_mem[1] = 16'd4; sx_mem[1] = 16'd10; sy_mem[1] = 16'd6;
    min_area = 16'd1; num_labels = 8'd1;
    run_frame(10, -1, 0);
    chk("stall_cnt", got_id.size(), 1);
    chk("stall_vcyc", valid_cycles, 11);
    chk("stall_stable", unstable, 0);
    if (got_id.size() == 1) chk("stall_cx", got_cx[0], 2);

    // frame_done during DIV
    run_frame(0, 8, 0);
    chk("ovr_div_cnt", overrun_cnt, 1);
    chk("ovr_div_rec", got_id.size(), 1);
    if (got_id.size() == 1) chk("ovr_div_cy", got_cy[0], 1);

    // frame_done in the NEXT->IDLE cycle is rejected
    run_frame(0, RISE_K + 1, 0);
    chk("ovr_last_cnt", overrun_cnt, 1);
    repeat (3) @(negedge clk);
    chk("ovr_last_idle", busy, 0);

    // Reset during DIV of label 2
    area_mem[2] = 16'd5; sx_mem[2] = 16'd17; sy_mem[2] = 16'd9;
    num_labels = 8'd2;
    @(negedge clk);
    frame_done = 1'b1; rpt_ready = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    repeat (29) @(negedge clk);
    chk("rstm_pre_id", obj_id, 2);
    reset_n = 1'b0;
    #1;
    chk("rstm_valid", rpt_valid, 0);
    chk("rstm_obj_id", obj_id, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_rpt", {rpt_id, rpt_area} | {8'd0, rpt_cx} | {8'd0, rpt_cy}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (rpt_valid || busy || sweep_done) bad++;
      end
      chk("rstm_quiet", bad, 0);
    end
    num_labels = 8'd1;
    run_frame(0, -1, 0);
    chk("rstm_after_cnt", got_id.size(), 1);
    if (got_id.size() == 1) chk("rstm_after_cx", got_cx[0], 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
